// File: rtl/mul8s_rr_sched.sv
// -----------------------------------------------------------------------------
// mul8s_rr_sched
//
// Round-robin scheduler that shares one registered 8x8 signed multiplier
// (instantiated by the parent and wired through the mul_* ports) among NREQ
// requesters.
//
// Each requester has a valid/ready request channel. Results come back on a
// single valid/ready response channel, tagged with the owning requester id.
//
// Optional feature macro: MUL8S_RR_SCHED_STATS_EN
//   When this macro is defined, the module adds the grant_cnt output. It holds
//   one 16-bit saturating grant counter per requester.
//
// Parameters
//   NREQ  number of requesters (2..16)
//   IDW   id width, derived from NREQ (leave at its default)
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_a      per-requester operand A, requester i at [8i+7:8i]
//   req_b      per-requester operand B, same packing
//   req_ready  one-hot grant, all zero when not accepting
//   rsp_valid  result valid (high in RSP state)
//   rsp_id     requester index owning the result
//   rsp_data   product, combinational pass-through of mul_o
//   rsp_ready  response sink ready
//   mul_a      registered operand A to the multiplier
//   mul_b      registered operand B to the multiplier
//   mul_o      registered multiplier product
//   busy       high while an operation is in MUL or RSP state
//   grant_cnt  (stats build only) 16 bits per requester, requester i at
//              [16i+15:16i]
// -----------------------------------------------------------------------------
module mul8s_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_o,
  output logic                 busy
`ifdef MUL8S_RR_SCHED_STATS_EN
  ,
  output logic [16*NREQ-1:0]   grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [7:0]      r_op_a;
  logic [7:0]      r_op_b;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_valid;
  logic            r_busy;

  logic            w_acc;
  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic            w_hs;
  logic [IDW-1:0]  w_ptr_next;
  logic [7:0]      w_sel_a;
  logic [7:0]      w_sel_b;

  // A new op can be taken when nothing is in flight, or when the current
  // result drains this very cycle.
  assign w_acc = (r_state == IDLE) | ((r_state == RSP) & rsp_ready);

  // Rotating priority search. The search starts at r_ptr and wraps modulo
  // NREQ. The index is kept one bit wider so the wrap also works when NREQ is
  // not a power of two.
  always_comb begin
    logic [IDW:0] idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = idx[IDW-1:0];
      end
    end
  end

  // A granted requester is valid by construction, so accept plus any valid
  // request means a handshake.
  assign w_hs = w_acc & w_found;

  assign w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
  assign w_sel_a    = req_a[{w_grant, 3'b000} +: 8];
  assign w_sel_b    = req_b[{w_grant, 3'b000} +: 8];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_acc & w_found & (w_grant == IDW'(gi));
    end
  endgenerate

  // Control FSM. rsp_valid and busy are registered here, next to the state
  // they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_hs) begin
      // In RSP this overlaps the drain, so the old result is consumed now.
      r_op_a      <= w_sel_a;
      r_op_b      <= w_sel_b;
      r_rsp_id    <= w_grant;
      r_ptr       <= w_ptr_next;
      r_state     <= MUL;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        MUL: begin
          r_state     <= RSP;
          r_rsp_valid <= 1'b1;
          r_busy      <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;
  // Operands stay frozen through MUL and RSP, so mul_o is stable while the
  // result is presented.
  assign rsp_data  = mul_o;

`ifdef MUL8S_RR_SCHED_STATS_EN
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (req_valid[gi] && req_ready[gi] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign grant_cnt[16*gi +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule
